// File: rtl/pixel_fifo.sv
// pixel_fifo: shift-register pixel FIFO, BURST-wide push, 1-pixel pop; `PIXEL_FIFO_MERGE_EN adds the OBJ overlay mode
module pixel_fifo #(
  parameter int DEPTH   = 16,
  parameter int BURST   = 8,
  parameter int PIXEL_W = 5,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [BURST*PIXEL_W-1:0]   push_data,
  output logic                       push_ready,
`ifdef PIXEL_FIFO_MERGE_EN
  input  logic                       merge,
`endif
  input  logic                       pop,
  output logic [PIXEL_W-1:0]         pop_data,
  output logic                       pop_valid,
  output logic [CNT_W-1:0]           count
);
  logic [PIXEL_W-1:0] r_ent [DEPTH];
  logic [PIXEL_W-1:0] w_nxt [DEPTH];
  logic [PIXEL_W-1:0] w_sl  [BURST];
  logic [CNT_W-1:0]   r_cnt, w_c, w_cnt_nxt;
  logic               w_pop, w_push, w_mrg;
  assign push_ready = r_cnt <= CNT_W'(DEPTH - BURST);
  assign pop_valid  = r_cnt != '0;
  assign pop_data   = r_ent[0];
  assign count      = r_cnt;
  assign w_pop      = pop && pop_valid;
  assign w_push     = push && push_ready;
  assign w_c        = r_cnt - CNT_W'(w_pop);
`ifdef PIXEL_FIFO_MERGE_EN
  assign w_mrg      = w_push && merge;
`else
  assign w_mrg      = 1'b0;
`endif
  always_comb begin
    for (int j = 0; j < BURST; j++) w_sl[j] = push_data[j*PIXEL_W +: PIXEL_W];
  end
  // pop shift first, then the burst lands relative to the post-pop count
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) w_nxt[i] = w_pop ? r_ent[i+1] : r_ent[i];
    w_nxt[DEPTH-1] = w_pop ? '0 : r_ent[DEPTH-1];
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < BURST; j++)
        if (w_push && !w_mrg && CNT_W'(i) == w_c + CNT_W'(j)) w_nxt[i] = w_sl[j];
`ifdef PIXEL_FIFO_MERGE_EN
    for (int i = 0; i < BURST; i++)
      if (w_mrg)
        w_nxt[i] = (CNT_W'(i) >= w_c) ? w_sl[i] :
                   (w_nxt[i][1:0] == 2'd0 && w_sl[i][1:0] != 2'd0) ? w_sl[i] : w_nxt[i];
`endif
    w_cnt_nxt = !w_push ? w_c :
                w_mrg   ? ((w_c > CNT_W'(BURST)) ? w_c : CNT_W'(BURST)) :
                          w_c + CNT_W'(BURST);
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ent <= w_nxt;
    end
  end
endmodule

// File: tb/tb_pixel_fifo.sv
// tb_pixel_fifo: scoreboard bench for pixel_fifo against a queue-based reference model
module tb_pixel_fifo;
  localparam int DEPTH = 16, BURST = 8, PW = 5, CW = $clog2(DEPTH + 1), BW = BURST * PW;
  logic clk = 1'b0;
  logic reset, flush, push, pop, push_ready, pop_valid;
  logic [BW-1:0] push_data;
  logic [PW-1:0] pop_data;
  logic [CW-1:0] count;
`ifdef PIXEL_FIFO_MERGE_EN
  logic merge;
`endif
  always #5 clk = ~clk;
  pixel_fifo #(.DEPTH(DEPTH), .BURST(BURST), .PIXEL_W(PW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .push(push), .push_data(push_data),
    .push_ready(push_ready),
`ifdef PIXEL_FIFO_MERGE_EN
    .merge(merge),
`endif
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .count(count)
  );
  typedef struct { int cnt; int rdy; int vld; int pix; } exp_t;
  exp_t exp_q[$];
  int   q[$];
  int   checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", 32'(count), e.cnt);
      chk("push_ready", 32'(push_ready), e.rdy);
      chk("pop_valid", 32'(pop_valid), e.vld);
      chk("pop_data", 32'(pop_data), e.pix);
    end
  end
  function automatic logic [BW-1:0] seq(input int b);
    logic [BW-1:0] r;
    for (int j = 0; j < BURST; j++) r[j*PW +: PW] = PW'(b + j);
    return r;
  endfunction
  function automatic logic [BW-1:0] pack(input int v [BURST]);
    logic [BW-1:0] r;
    for (int j = 0; j < BURST; j++) r[j*PW +: PW] = PW'(v[j]);
    return r;
  endfunction
  task automatic step(input bit rs, input bit fl, input bit ps, input logic [BW-1:0] d,
                      input bit pp, input bit mg);
    bit rdy, m;
    int s;
    reset = rs; flush = fl; push = ps; push_data = d; pop = pp;
`ifdef PIXEL_FIFO_MERGE_EN
    merge = mg;
    m = mg;
`else
    m = 1'b0 & mg;
`endif
    exp_q.push_back('{q.size(), int'(q.size() <= DEPTH - BURST), int'(q.size() != 0),
                      (q.size() != 0) ? q[0] : 0});
    @(posedge clk);
    if (rs || fl) q.delete();
    else begin
      rdy = q.size() <= DEPTH - BURST;
      if (pp && q.size() > 0) void'(q.pop_front());
      if (ps && rdy)
        for (int j = 0; j < BURST; j++) begin
          s = int'(d[j*PW +: PW]);
          if (m && j < q.size()) begin
            if ((q[j] & 3) == 0 && (s & 3) != 0) q[j] = s;
          end else q.push_back(s);
        end
    end
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0, 0);
  endtask
  task automatic pops(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, '0, 1, 0);
  endtask
  initial begin
    int cm [BURST];
    reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
`ifdef PIXEL_FIFO_MERGE_EN
    merge = 1'b0;
`endif
    @(posedge clk); #1;
    idle(1);
    step(0, 0, 1, seq(1), 0, 0);
    pops(8); idle(1);
    step(0, 0, 1, seq(1), 0, 0);
    step(0, 0, 1, seq(9), 0, 0);
    step(0, 0, 1, seq(17), 0, 0);
    pops(16); idle(1);
    step(0, 0, 1, seq(1), 0, 0);
    step(0, 0, 1, seq(9), 0, 0);
    pops(7);
    step(0, 0, 1, seq(20), 1, 0);
    pops(16); idle(1);
    pops(1); idle(1);
    step(0, 0, 1, seq(1), 0, 0);
    pops(3);
    step(0, 1, 1, seq(3), 1, 0);
    idle(1);
    step(0, 0, 1, seq(1), 0, 0);
    step(1, 0, 1, seq(9), 1, 0);
    idle(1);
`ifdef PIXEL_FIFO_MERGE_EN
    cm = '{1, 2, 3, 5, 4, 6, 8, 9};
    step(0, 0, 1, pack(cm), 0, 0);
    pops(5);
    cm = '{5, 9, 15, 13, 4, 18, 8, 12};
    step(0, 0, 1, pack(cm), 0, 1);
    pops(8); idle(1);
    step(0, 0, 1, seq(1), 0, 0);
    cm = '{4, 8, 12, 16, 20, 24, 28, 0};
    step(0, 0, 1, pack(cm), 0, 1);
    pops(8); idle(1);
`else
    cm = '{0, 0, 0, 0, 0, 0, 0, 0};
    step(0, 0, 1, pack(cm), 0, 0);
    pops(8);
`endif
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
